// File: rtl/stream_mem_join_pkg.sv
// stream_mem_join_pkg
//   Shared types and the combining function for stream_mem_join.
//   - op_e : per-transaction ALU operation carried on the operand stream.
//   - alu  : combines a RAM word (a) with an operand (b). It works on
//            ALU_MAX_W bits. Callers zero-extend their operands and keep
//            the low DATA_W bits of the result, so DATA_W must not exceed
//            ALU_MAX_W. With that truncation, ADD wraps modulo 2**DATA_W.
package stream_mem_join_pkg;

  typedef enum logic [1:0] {
    OP_XOR = 2'd0,
    OP_ADD = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  localparam int ALU_MAX_W = 64;

  function automatic logic [ALU_MAX_W-1:0] alu(input op_e                  op,
                                               input logic [ALU_MAX_W-1:0] a,
                                               input logic [ALU_MAX_W-1:0] b);
    logic [ALU_MAX_W-1:0] r;
    case (op)
      OP_XOR:  r = a ^ b;
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stream_mem_join_ram.sv
// stream_mem_join_ram
//   1-write / 1-read RAM with a registered, enabled read port. The read
//   register only loads when rd_en_i is high, so the read word stays stable
//   while downstream is stalled. RAM contents and the read register are not
//   reset.
//
//   Optional macro STREAM_MEM_JOIN_WR_FWD_EN: a read and a write to the same
//   address in the same cycle return the new write data (write-first).
//   Without it the old contents are returned (read-first).
//
// Ports
//   clk        in   clock
//   wr_en_i    in   write enable
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   rd_en_i    in   read enable (loads rd_data_o on the next edge)
//   rd_addr_i  in   read address
//   rd_data_o  out  registered read data
module stream_mem_join_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    rd_data_d = mem_q[rd_addr_i];
`ifdef STREAM_MEM_JOIN_WR_FWD_EN
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_d = wr_data_i;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stream_mem_join.sv
// stream_mem_join
//   Reads a RAM word for each address beat on cmdA, joins it with the next
//   operand beat on cmdB, combines the pair with the op carried on cmdB and
//   presents the result on a registered, fully backpressured rsp stream.
//   Sustains one result per cycle. io_rspCount counts rsp transfers and
//   wraps at 2**CNT_W.
//
//   Optional macro STREAM_MEM_JOIN_WR_FWD_EN (see stream_mem_join_ram):
//   write-first forwarding on a same-address read/write collision.
//
// Ports
//   clk, reset                          clock, async active-high reset
//   io_memWrite_valid/_payload_address/_payload_data   RAM write port
//   io_cmdA_valid/_ready/_payload       address stream
//   io_cmdB_valid/_ready/_payload_data/_payload_op     operand stream
//   io_rsp_valid/_ready/_payload        result stream
//   io_rspCount                         rsp transfer counter
module stream_mem_join
  import stream_mem_join_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_memWrite_valid,
  input  logic [ADDR_W-1:0] io_memWrite_payload_address,
  input  logic [DATA_W-1:0] io_memWrite_payload_data,
  input  logic              io_cmdA_valid,
  output logic              io_cmdA_ready,
  input  logic [ADDR_W-1:0] io_cmdA_payload,
  input  logic              io_cmdB_valid,
  output logic              io_cmdB_ready,
  input  logic [DATA_W-1:0] io_cmdB_payload_data,
  input  logic [1:0]        io_cmdB_payload_op,
  output logic              io_rsp_valid,
  input  logic              io_rsp_ready,
  output logic [DATA_W-1:0] io_rsp_payload,
  output logic [CNT_W-1:0]  io_rspCount
);

  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_payload_q, rsp_payload_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cmdA_fire;
  logic              join_ready;
  logic              join_fire;
  logic              rsp_fire;
  logic [DATA_W-1:0] result;

  // Handshakes: a read slot frees up in the same cycle its word is joined.
  assign join_ready    = !rsp_valid_q || io_rsp_ready;
  assign join_fire     = rd_valid_q && io_cmdB_valid && join_ready;
  assign io_cmdA_ready = !rd_valid_q || join_fire;
  assign io_cmdB_ready = join_fire;
  assign cmdA_fire     = io_cmdA_valid && io_cmdA_ready;
  assign rsp_fire      = rsp_valid_q && io_rsp_ready;

  // Read stage R: RAM read register, loaded only on cmdA fire
  stream_mem_join_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk      (clk),
    .wr_en_i  (io_memWrite_valid),
    .wr_addr_i(io_memWrite_payload_address),
    .wr_data_i(io_memWrite_payload_data),
    .rd_en_i  (cmdA_fire),
    .rd_addr_i(io_cmdA_payload),
    .rd_data_o(rd_data)
  );

  // Join + ALU: combinational, feeds the output register
  assign result = DATA_W'(alu(op_e'(io_cmdB_payload_op),
                              ALU_MAX_W'(rd_data),
                              ALU_MAX_W'(io_cmdB_payload_data)));

  always_comb begin
    rd_valid_d    = rd_valid_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_payload_d = rsp_payload_q;
    cnt_d         = cnt_q;

    if (cmdA_fire) begin
      rd_valid_d = 1'b1;
    end else if (join_fire) begin
      rd_valid_d = 1'b0;
    end

    if (join_fire) begin
      rsp_valid_d   = 1'b1;
      rsp_payload_d = result;
    end else if (rsp_fire) begin
      rsp_valid_d = 1'b0;
    end

    if (rsp_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output stage: registered rsp and transfer counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_payload_q <= '0;
      cnt_q         <= '0;
    end else begin
      rd_valid_q    <= rd_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_payload_q <= rsp_payload_d;
      cnt_q         <= cnt_d;
    end
  end

  assign io_rsp_valid   = rsp_valid_q;
  assign io_rsp_payload = rsp_payload_q;
  assign io_rspCount    = cnt_q;

endmodule
